// File: rtl/meter_session_timer.sv
// ---------------------------------------------------------------------------
// meter_session_timer
//   Parking-session elapsed-time counter. Divides clk into one-second ticks,
//   counts whole seconds while a session runs, supports pause/resume and
//   freezes the final count on stop or saturation for the cost stage.
//
// Ports
//   clk           in   1      system clock, rising edge
//   rst           in   1      synchronous active-high reset
//   start         in   1      level button; rising edge starts a session
//   pause         in   1      level button; rising edge toggles RUN <-> PAUSE
//   stop          in   1      level button; rising edge ends the session
//   sec_count     out  CNT_W  elapsed whole seconds of current/last session
//   running       out  1      high while in RUN
//   sec_tick      out  1      one-cycle pulse on each counted second
//   session_done  out  1      one-cycle pulse on entry to HOLD
// ---------------------------------------------------------------------------
module meter_session_timer #(
    parameter int unsigned CLK_DIV = 100_000_000,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned MAX_SEC = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [CNT_W-1:0] sec_count,
    output logic             running,
    output logic             sec_tick,
    output logic             session_done
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SEC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    // {stop, pause, start}: one sampling flop plus a previous-value flop
    logic [2:0] btn_s_q, btn_prev_q;
    logic [2:0] btn_edge;
    logic       stop_ev, pause_ev, start_ev;
    logic       wrap, reach_max;

    // Both flops reset high so a button held through reset never looks like an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s_q    <= 3'b111;
            btn_prev_q <= 3'b111;
        end else begin
            btn_s_q    <= {stop, pause, start};
            btn_prev_q <= btn_s_q;
        end
    end

    // Prioritised events: stop > pause > start, losers are dropped
    always_comb begin
        btn_edge  = btn_s_q & ~btn_prev_q;
        stop_ev   = btn_edge[2];
        pause_ev  = btn_edge[1] & ~btn_edge[2];
        start_ev  = btn_edge[0] & ~btn_edge[1] & ~btn_edge[2];
        wrap      = (div_q == DIV_LAST);
        reach_max = ((cnt_q + CNT_W'(1)) == CNT_MAX);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ev) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop_ev)               state_d = S_HOLD;
                else if (pause_ev)         state_d = S_PAUSE;
                else if (wrap && reach_max) state_d = S_HOLD;
            end
            S_PAUSE: begin
                if (stop_ev)       state_d = S_HOLD;
                else if (pause_ev) state_d = S_RUN;
            end
            S_HOLD: begin
                if (start_ev) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        run_d  = (state_d == S_RUN);
        done_d = (state_d == S_HOLD) && (state_q != S_HOLD);
        unique case (state_q)
            S_IDLE: begin
                div_d = '0;
                cnt_d = '0;
            end
            S_RUN: begin
                // Any stop or pause event freezes the divider in this cycle
                if (!stop_ev && !pause_ev) begin
                    if (wrap) begin
                        div_d = '0;
                        if (cnt_q < CNT_MAX) begin
                            cnt_d  = cnt_q + CNT_W'(1);
                            tick_d = 1'b1;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            S_PAUSE: begin
            end
            S_HOLD: begin
                if (start_ev) begin
                    div_d = '0;
                    cnt_d = '0;
                end
            end
            default: begin
                div_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    assign sec_count    = cnt_q;
    assign running      = run_q;
    assign sec_tick     = tick_q;
    assign session_done = done_q;

endmodule

// File: tb/tb_meter_session_timer.sv
// Bench for meter_session_timer with CLK_DIV=4. Expected tick/done events
// (cycle stamp plus output values) are queued by the stimulus and popped by
// per-DUT monitors whenever sec_tick or session_done is seen.
module tb_meter_session_timer;

    typedef struct {
        int cyc;
        int cnt;
        int tick;
        int done;
        int run;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, pause, stop;
    logic        start5, pause5, stop5;
    logic [11:0] sec_count, sec_count5;
    logic        running, sec_tick, session_done;
    logic        running5, sec_tick5, session_done5;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t exp5_q[$];

    meter_session_timer #(.CLK_DIV(4), .CNT_W(12), .MAX_SEC(4095)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
        .sec_count(sec_count), .running(running), .sec_tick(sec_tick),
        .session_done(session_done)
    );

    meter_session_timer #(.CLK_DIV(4), .CNT_W(12), .MAX_SEC(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .pause(pause5), .stop(stop5),
        .sec_count(sec_count5), .running(running5), .sec_tick(sec_tick5),
        .session_done(session_done5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_rec(input string tag, input exp_t e, input int cnt,
                           input int tick, input int done, input int run);
        n_cmp = n_cmp + 1;
        if (e.cyc != cyc || e.cnt != cnt || e.tick != tick || e.done != done || e.run != run) begin
            n_bad = n_bad + 1;
            $display("FAIL %s_event: got cyc=%0d cnt=%0d tick=%0d done=%0d run=%0d expected cyc=%0d cnt=%0d tick=%0d done=%0d run=%0d",
                     tag, cyc, cnt, tick, done, run, e.cyc, e.cnt, e.tick, e.done, e.run);
        end
    endtask

    task automatic miss(input string tag, input exp_t e);
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL %s_missed: no event by cyc %0d, expected one at cyc=%0d cnt=%0d",
                 tag, cyc, e.cyc, e.cnt);
    endtask

    // Monitor for the main DUT
    always @(negedge clk) begin
        exp_t e;
        if (sec_tick || session_done) begin
            if (exp_q.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_bad = n_bad + 1;
                $display("FAIL main_unexpected @cyc %0d: got tick=%0d done=%0d cnt=%0d expected no event",
                         cyc, sec_tick, session_done, sec_count);
            end else begin
                e = exp_q.pop_front();
                cmp_rec("main", e, int'(sec_count), int'(sec_tick), int'(session_done), int'(running));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            miss("main", e);
        end
    end

    // Monitor for the MAX_SEC=5 DUT
    always @(negedge clk) begin
        exp_t e;
        if (sec_tick5 || session_done5) begin
            if (exp5_q.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_bad = n_bad + 1;
                $display("FAIL sat_unexpected @cyc %0d: got tick=%0d done=%0d cnt=%0d expected no event",
                         cyc, sec_tick5, session_done5, sec_count5);
            end else begin
                e = exp5_q.pop_front();
                cmp_rec("sat", e, int'(sec_count5), int'(sec_tick5), int'(session_done5), int'(running5));
            end
        end else if (exp5_q.size() > 0 && exp5_q[0].cyc < cyc) begin
            e = exp5_q.pop_front();
            miss("sat", e);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Ticks n=first..last of a run whose tick 'first' lands at cycle t0
    task automatic push_ticks(input int t0, input int first, input int last);
        for (int n = first; n <= last; n++)
            exp_q.push_back('{t0 + 4 * (n - first), n, 1, 0, 1});
    endtask

    initial begin
        int r, rb, q, s, r2, r3, r4, r5;
        rst = 1'b1; start = 1'b1; pause = 1'b0; stop = 1'b0;
        start5 = 1'b0; pause5 = 1'b0; stop5 = 1'b0;

        // Reset with start held; no session until start falls and rises
        step(3);
        chk("rst_count", int'(sec_count), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_tick", int'(sec_tick), 0);
        chk("rst_done", int'(session_done), 0);
        rst = 1'b0;
        step(8);
        chk("held_start_no_run", int'(running), 0);
        chk("held_start_count", int'(sec_count), 0);

        // Session A: 40 cycles of RUN -> 10 seconds
        start = 1'b0; step(2); start = 1'b1;
        r = cyc + 2;
        push_ticks(r + 4, 1, 10);
        wait_until(r - 1);
        chk("run_latency_pre", int'(running), 0);
        wait_until(r);
        chk("run_latency", int'(running), 1);
        wait_until(r + 40);
        chk("count_after_40", int'(sec_count), 10);
        stop = 1'b1;
        exp_q.push_back('{r + 42, 10, 0, 1, 0});
        step(2); stop = 1'b0; start = 1'b0;

        // Session B: pause at count 3 / divider 2, resume, stop at 7
        step(2); start = 1'b1;
        rb = cyc + 2;
        push_ticks(rb + 4, 1, 3);
        wait_until(rb);
        chk("restart_clears", int'(sec_count), 0);
        wait_until(rb + 13);
        pause = 1'b1;
        step(2);
        chk("paused_running", int'(running), 0);
        chk("paused_count", int'(sec_count), 3);
        pause = 1'b0;
        step(18);
        chk("paused_long_count", int'(sec_count), 3);
        wait_until(rb + 35);
        pause = 1'b1;
        q = rb + 35;
        push_ticks(q + 4, 4, 7);
        step(2); pause = 1'b0;
        chk("resume_running", int'(running), 1);
        s = q + 16;
        wait_until(s);
        stop = 1'b1;
        exp_q.push_back('{s + 2, 7, 0, 1, 0});
        step(2); stop = 1'b0;
        chk("stop_running", int'(running), 0);
        step(2); stop = 1'b1;
        step(3); stop = 1'b0;
        chk("hold_count", int'(sec_count), 7);

        // HOLD -> RUN on start clears the count
        start = 1'b0; step(2); start = 1'b1;
        r2 = cyc + 2;
        push_ticks(r2 + 4, 1, 2);
        wait_until(r2);
        chk("hold_start_count", int'(sec_count), 0);
        chk("hold_start_running", int'(running), 1);

        // Stop and pause edges together: stop wins
        wait_until(r2 + 8);
        stop = 1'b1; pause = 1'b1;
        exp_q.push_back('{r2 + 10, 2, 0, 1, 0});
        step(2); stop = 1'b0; pause = 1'b0; start = 1'b0;
        chk("stop_pause_count", int'(sec_count), 2);

        // Stop on a wrap cycle: no increment, no tick
        step(2); start = 1'b1;
        r3 = cyc + 2;
        push_ticks(r3 + 4, 1, 1);
        wait_until(r3 + 6);
        stop = 1'b1;
        exp_q.push_back('{r3 + 8, 1, 0, 1, 0});
        step(2); stop = 1'b0; start = 1'b0;
        step(1);
        chk("stop_wrap_count", int'(sec_count), 1);

        // Reset mid-RUN
        step(1); start = 1'b1;
        r4 = cyc + 2;
        push_ticks(r4 + 4, 1, 1);
        wait_until(r4 + 5);
        rst = 1'b1;
        step(1);
        chk("midrst_count", int'(sec_count), 0);
        chk("midrst_running", int'(running), 0);
        chk("midrst_done", int'(session_done), 0);
        rst = 1'b0; start = 1'b0;

        // Saturation at MAX_SEC=5
        step(2); start5 = 1'b1;
        r5 = cyc + 2;
        for (int n = 1; n <= 4; n++) exp5_q.push_back('{r5 + 4 * n, n, 1, 0, 1});
        exp5_q.push_back('{r5 + 20, 5, 1, 1, 0});
        wait_until(r5 + 20);
        chk("sat_count", int'(sec_count5), 5);
        step(100);
        chk("sat_hold_count", int'(sec_count5), 5);
        chk("sat_hold_running", int'(running5), 0);

        step(4);
        chk("main_queue_drained", exp_q.size(), 0);
        chk("sat_queue_drained", exp5_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
